ps2_key_tracker: RTL and testbench

//  Parametrised PS/2 scancode tracker/display for the keyboard experiment. Consumes

---
 rtl/ps2_key_tracker_pkg.sv | 43 ++++
 rtl/ps2_key_tracker_if.sv | 27 ++
 rtl/ps2_key_tracker_hex_to_seg7.sv | 13 +
 rtl/ps2_key_tracker.sv | 152 +++++++++++++++
 tb/tb_ps2_key_tracker.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_tracker_pkg.sv
// Shared scancode constants, FSM encoding and 7-seg patterns
// for the PS/2 key tracker.
package ps2_key_tracker_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERR1  = 8'hFF;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_e;

    // Active-low {g,f,e,d,c,b,a}, segment a in bit 0
    function automatic logic [6:0] hex_seg7(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Receiver-side byte strobe plus tracker status/display outputs.
// The tracker is the slave; the receiver/board side is the master.
interface ps2_key_tracker_if #(
    parameter int EXT_EN     = 1,
    parameter int CNT_DIGITS = 2
);
    localparam int NCODE = 2 + 2 * EXT_EN;

    logic                      data_valid;
    logic [7:0]                data;
    logic                      key_down;
    logic [15:0]               cur_code;
    logic [4*CNT_DIGITS-1:0]   press_cnt;
    logic [7*NCODE-1:0]        hex_code;
    logic [7*CNT_DIGITS-1:0]   hex_cnt;

    modport master (
        output data_valid, data,
        input  key_down, cur_code, press_cnt, hex_code, hex_cnt
    );

    modport slave (
        input  data_valid, data,
        output key_down, cur_code, press_cnt, hex_code, hex_cnt
    );

endinterface

// File: rtl/ps2_key_tracker_hex_to_seg7.sv
// One hex digit to active-low 7-segment pattern, with blanking.
// Purely combinational; display polarity is handled by the top.
import ps2_key_tracker_pkg::*;

module hex_to_seg7 (
    input  logic [3:0] hex_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    assign seg_o = blank_i ? SEG_BLANK : hex_seg7(hex_i);

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 make/break/E0 decoder with held-key tracking, BCD press
// counter and registered 7-seg drive for code and count.
import ps2_key_tracker_pkg::*;

module ps2_key_tracker #(
    parameter int EXT_EN      = 1,
    parameter int CNT_DIGITS  = 2,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic            clk,
    input  logic            reset,
    ps2_key_tracker_if.slave bus
);

    localparam int NCODE = 2 + 2 * EXT_EN;
    localparam int CW    = 4 * CNT_DIGITS;
    localparam logic [6:0] POL = (SEG_ACT_LOW != 0) ? 7'h00 : 7'h7F;

    state_e             state_q, state_d;
    logic               key_down_q, key_down_d;
    logic [15:0]        cur_code_q, cur_code_d;
    logic [CW-1:0]      press_cnt_q, press_cnt_d;
    logic [7*NCODE-1:0] hex_code_q, hex_code_d;
    logic [7*CNT_DIGITS-1:0] hex_cnt_q, hex_cnt_d;

    logic [7*NCODE-1:0]      seg_code;
    logic [7*CNT_DIGITS-1:0] seg_cnt;

    logic is_ext, is_brk, is_err;

    assign is_ext = (bus.data == SC_EXT);
    assign is_brk = (bus.data == SC_BREAK);
    assign is_err = (bus.data == SC_ERR0) || (bus.data == SC_ERR1);

    always_comb begin : nxt
        logic        mk, bk, ext, hit, carry;
        logic [15:0] key;
        logic [3:0]  dig;
        state_d     = state_q;
        key_down_d  = key_down_q;
        cur_code_d  = cur_code_q;
        press_cnt_d = press_cnt_q;
        mk    = 1'b0;
        bk    = 1'b0;
        ext   = 1'b0;
        carry = 1'b1;
        dig   = 4'h0;
        if (bus.data_valid) begin
            if (is_err) begin
                state_d = S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        unique case (1'b1)
                            is_ext:  state_d = (EXT_EN != 0) ? S_EXT : S_IDLE;
                            is_brk:  state_d = S_BRK;
                            default: mk = 1'b1;
                        endcase
                    end
                    S_EXT: begin
                        unique case (1'b1)
                            is_brk:  state_d = S_EXT_BRK;
                            is_ext:  state_d = S_EXT;
                            default: begin
                                mk      = 1'b1;
                                ext     = 1'b1;
                                state_d = S_IDLE;
                            end
                        endcase
                    end
                    S_BRK: begin
                        if (!(is_brk || is_ext)) begin
                            bk      = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    default: begin
                        if (!(is_brk || is_ext)) begin
                            bk      = 1'b1;
                            ext     = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                endcase
            end
        end
        key = {ext ? SC_EXT : 8'h00, bus.data};
        hit = key_down_q && (key == cur_code_q);
        // A repeated make of the held key is typematic, not a new press
        if (mk && !hit) begin
            cur_code_d = key;
            key_down_d = 1'b1;
            for (int i = 0; i < CNT_DIGITS; i++) begin
                dig = press_cnt_q[4*i +: 4];
                if (carry) begin
                    if (dig == 4'd9) begin
                        press_cnt_d[4*i +: 4] = 4'd0;
                    end else begin
                        press_cnt_d[4*i +: 4] = dig + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        if (bk && hit) begin
            key_down_d = 1'b0;
        end
    end

    for (genvar g = 0; g < NCODE; g++) begin : g_code
        hex_to_seg7 u_seg (
            .hex_i   (cur_code_d[4*g +: 4]),
            .blank_i (!key_down_d),
            .seg_o   (seg_code[7*g +: 7])
        );
        assign hex_code_d[7*g +: 7] = seg_code[7*g +: 7] ^ POL;
    end

    for (genvar g = 0; g < CNT_DIGITS; g++) begin : g_cnt
        hex_to_seg7 u_seg (
            .hex_i   (press_cnt_d[4*g +: 4]),
            .blank_i (1'b0),
            .seg_o   (seg_cnt[7*g +: 7])
        );
        assign hex_cnt_d[7*g +: 7] = seg_cnt[7*g +: 7] ^ POL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            key_down_q  <= 1'b0;
            cur_code_q  <= 16'h0000;
            press_cnt_q <= '0;
            hex_code_q  <= {NCODE{SEG_BLANK ^ POL}};
            hex_cnt_q   <= {CNT_DIGITS{hex_seg7(4'h0) ^ POL}};
        end else begin
            state_q     <= state_d;
            key_down_q  <= key_down_d;
            cur_code_q  <= cur_code_d;
            press_cnt_q <= press_cnt_d;
            hex_code_q  <= hex_code_d;
            hex_cnt_q   <= hex_cnt_d;
        end
    end

    assign bus.key_down  = key_down_q;
    assign bus.cur_code  = cur_code_q;
    assign bus.press_cnt = press_cnt_q;
    assign bus.hex_code  = hex_code_q;
    assign bus.hex_cnt   = hex_cnt_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed scancode sequences plus random byte streams against
// a prefix-flag / held-key reference model.
module tb_ps2_key_tracker;

    localparam int EXT_EN     = 1;
    localparam int CNT_DIGITS = 2;

    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk = 1'b0;
    logic reset = 1'b0;

    ps2_key_tracker_if #(.EXT_EN(EXT_EN), .CNT_DIGITS(CNT_DIGITS)) bus ();

    ps2_key_tracker #(
        .EXT_EN      (EXT_EN),
        .CNT_DIGITS  (CNT_DIGITS),
        .SEG_ACT_LOW (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: pending prefixes as flags, held key, count
    bit          m_ext, m_brk, m_held;
    logic [15:0] m_code;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ext  = 0;
        m_brk  = 0;
        m_held = 0;
        m_code = 16'h0;
        m_cnt  = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [15:0] k;
        if (b == 8'h00 || b == 8'hFF) begin
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hE0) begin
            if (!m_brk) m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            k = {m_ext ? 8'hE0 : 8'h00, b};
            if (m_brk) begin
                if (m_held && k == m_code) m_held = 0;
            end else if (!(m_held && k == m_code)) begin
                m_code = k;
                m_held = 1;
                m_cnt  = (m_cnt + 1) % 100;
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic compare(input string tag);
        logic [27:0] eh;
        logic [13:0] ec;
        for (int i = 0; i < 4; i++)
            eh[7*i +: 7] = m_held ? SEG[(m_code >> (4*i)) & 16'hF] : 7'h7F;
        ec = {SEG[m_cnt / 10], SEG[m_cnt % 10]};
        check({tag, ".key_down"}, 32'(bus.key_down), 32'(m_held));
        check({tag, ".cur_code"}, 32'(bus.cur_code), 32'(m_code));
        check({tag, ".press_cnt"}, 32'(bus.press_cnt),
              32'({4'(m_cnt / 10), 4'(m_cnt % 10)}));
        check({tag, ".hex_code"}, 32'(bus.hex_code), 32'(eh));
        check({tag, ".hex_cnt"}, 32'(bus.hex_cnt), 32'(ec));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.data_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        @(negedge clk);
        bus.data_valid = 1'b1;
        bus.data = b;
        @(negedge clk);
        bus.data_valid = 1'b0;
        bus.data = 8'h00;
        model_byte(b);
        compare(tag);
    endtask

    logic [7:0] pool [6] = '{8'h1C, 8'h32, 8'h75, 8'h23, 8'h6B, 8'h1C};

    initial begin
        bus.data_valid = 1'b0;
        bus.data = 8'h00;
        model_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compare("reset");
        check("reset.hex_code_blank", 32'(bus.hex_code), 32'h0FFFFFFF);
        check("reset.hex_cnt_zero", 32'(bus.hex_cnt), 32'h2040);

        send(8'h1C, "t1");
        check("t1.cur_code", 32'(bus.cur_code), 32'h001C);
        check("t1.press_cnt", 32'(bus.press_cnt), 32'h01);

        send(8'h1C, "t2a");
        send(8'h1C, "t2b");
        send(8'h1C, "t2c");
        send(8'hF0, "t2d");
        send(8'h1C, "t2e");
        check("t2.press_cnt", 32'(bus.press_cnt), 32'h01);
        check("t2.key_down", 32'(bus.key_down), 32'h0);

        send(8'hE0, "t3a");
        send(8'h75, "t3b");
        check("t3.cur_code", 32'(bus.cur_code), 32'hE075);
        check("t3.press_cnt", 32'(bus.press_cnt), 32'h02);
        send(8'hE0, "t3c");
        send(8'hF0, "t3d");
        send(8'h75, "t3e");
        check("t3.key_down", 32'(bus.key_down), 32'h0);

        do_reset();
        compare("t4.reset");
        for (int i = 0; i < 100; i++) begin
            send(8'(8'h01 + i), "t4m");
            send(8'hF0, "t4f");
            send(8'(8'h01 + i), "t4b");
        end
        check("t4.wrap_cnt", 32'(bus.press_cnt), 32'h00);
        check("t4.wrap_hex", 32'(bus.hex_cnt), 32'h2040);

        send(8'h1C, "t5a");
        send(8'h32, "t5b");
        send(8'hF0, "t5c");
        send(8'h1C, "t5d");
        check("t5.cur_code", 32'(bus.cur_code), 32'h0032);
        check("t5.key_down", 32'(bus.key_down), 32'h1);
        check("t5.press_cnt", 32'(bus.press_cnt), 32'h02);

        send(8'hE0, "t6a");
        send(8'hF0, "t6b");
        do_reset();
        send(8'h1C, "t6c");
        check("t6.cur_code", 32'(bus.cur_code), 32'h001C);
        check("t6.press_cnt", 32'(bus.press_cnt), 32'h01);

        send(8'hE0, "err.a");
        send(8'hFF, "err.b");
        send(8'h32, "err.c");
        check("err.cur_code", 32'(bus.cur_code), 32'h0032);

        for (int n = 0; n < 1500; n++) begin
            int r;
            logic [7:0] b;
            r = int'($urandom_range(0, 99));
            if (r < 4)       b = 8'h00;
            else if (r < 8)  b = 8'hFF;
            else if (r < 25) b = 8'hE0;
            else if (r < 45) b = 8'hF0;
            else             b = pool[$urandom_range(0, 5)];
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                compare("rnd.reset");
            end
            send(b, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
